// File: rtl/ps2_ascii_decoder.sv
// PS/2 scan-code-set-2 receiver and ASCII decoder feeding the text-mode video memory.
// Frames are validated, prefixes/shift/caps tracked, printable keys emitted as one-cycle strobes.
module ps2_ascii_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       p_valid,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  logic [SYNC_STAGES-1:0] clkSync_q, dataSync_q;
  logic                   prevClk_q;
  logic [3:0]             bitCnt_q;
  logic [9:0]             frame_q;
  logic [TW-1:0]          timeout_q;
  logic                   scanValid_q;
  logic [7:0]             scanByte_q;
  logic                   frameErr_q;

  logic                   fallEdge;
  logic [10:0]            frame_d;
  logic                   frameOk;

  state_t                 state_q;
  logic                   shiftL_q, shiftR_q, caps_q, pValid_q;
  logic [7:0]             key_q;

  logic                   lookupHit;
  logic [7:0]             baseChar, lookupChar;

  assign fallEdge = prevClk_q & ~clkSync_q[SYNC_STAGES-1];
  // frame_q keeps the ten most recent samples, so frame_d[0] is the start bit on the 11th edge
  assign frame_d  = {dataSync_q[SYNC_STAGES-1], frame_q};
  assign frameOk  = ~frame_d[0] & frame_d[10] & (^frame_d[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync_q   <= '1;
      dataSync_q  <= '1;
      prevClk_q   <= 1'b1;
      bitCnt_q    <= '0;
      frame_q     <= '0;
      timeout_q   <= '0;
      scanValid_q <= 1'b0;
      scanByte_q  <= '0;
      frameErr_q  <= 1'b0;
    end else begin
      clkSync_q   <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk};
      dataSync_q  <= {dataSync_q[SYNC_STAGES-2:0], ps2_data};
      prevClk_q   <= clkSync_q[SYNC_STAGES-1];
      scanValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      if (fallEdge) begin
        timeout_q <= '0;
        frame_q   <= frame_d[10:1];
        if (bitCnt_q == 4'd10) begin
          bitCnt_q <= '0;
          if (frameOk) begin
            scanValid_q <= 1'b1;
            scanByte_q  <= frame_d[8:1];
          end else begin
            frameErr_q <= 1'b1;
          end
        end else begin
          bitCnt_q <= bitCnt_q + 4'd1;
        end
      end else if (bitCnt_q != 4'd0) begin
        // A stalled partial frame is dropped silently
        if (timeout_q == TW'(TIMEOUT_CYCLES)) begin
          bitCnt_q  <= '0;
          timeout_q <= '0;
        end else begin
          timeout_q <= timeout_q + TW'(1);
        end
      end
    end
  end

  always_comb begin
    lookupHit = 1'b1;
    baseChar  = 8'h00;
    case (scanByte_q)
      8'h1C: baseChar = 8'h61;  8'h32: baseChar = 8'h62;  8'h21: baseChar = 8'h63;
      8'h23: baseChar = 8'h64;  8'h24: baseChar = 8'h65;  8'h2B: baseChar = 8'h66;
      8'h34: baseChar = 8'h67;  8'h33: baseChar = 8'h68;  8'h43: baseChar = 8'h69;
      8'h3B: baseChar = 8'h6A;  8'h42: baseChar = 8'h6B;  8'h4B: baseChar = 8'h6C;
      8'h3A: baseChar = 8'h6D;  8'h31: baseChar = 8'h6E;  8'h44: baseChar = 8'h6F;
      8'h4D: baseChar = 8'h70;  8'h15: baseChar = 8'h71;  8'h2D: baseChar = 8'h72;
      8'h1B: baseChar = 8'h73;  8'h2C: baseChar = 8'h74;  8'h3C: baseChar = 8'h75;
      8'h2A: baseChar = 8'h76;  8'h1D: baseChar = 8'h77;  8'h22: baseChar = 8'h78;
      8'h35: baseChar = 8'h79;  8'h1A: baseChar = 8'h7A;
      8'h16: baseChar = 8'h31;  8'h1E: baseChar = 8'h32;  8'h26: baseChar = 8'h33;
      8'h25: baseChar = 8'h34;  8'h2E: baseChar = 8'h35;  8'h36: baseChar = 8'h36;
      8'h3D: baseChar = 8'h37;  8'h3E: baseChar = 8'h38;  8'h46: baseChar = 8'h39;
      8'h45: baseChar = 8'h30;
      8'h29: baseChar = 8'h20;  8'h5A: baseChar = 8'h0A;  8'h66: baseChar = 8'h08;
      default: lookupHit = 1'b0;
    endcase

    lookupChar = baseChar;
    if (baseChar >= 8'h61 && baseChar <= 8'h7A && (shift_held ^ caps_q)) begin
      lookupChar = baseChar - 8'h20;
    end else if (baseChar >= 8'h30 && baseChar <= 8'h39 && shift_held) begin
      case (baseChar)
        8'h31: lookupChar = 8'h21;  8'h32: lookupChar = 8'h40;  8'h33: lookupChar = 8'h23;
        8'h34: lookupChar = 8'h24;  8'h35: lookupChar = 8'h25;  8'h36: lookupChar = 8'h5E;
        8'h37: lookupChar = 8'h26;  8'h38: lookupChar = 8'h2A;  8'h39: lookupChar = 8'h28;
        default: lookupChar = 8'h29;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shiftL_q <= 1'b0;
      shiftR_q <= 1'b0;
      caps_q   <= 1'b0;
      key_q    <= '0;
      pValid_q <= 1'b0;
    end else begin
      pValid_q <= 1'b0;
      if (scanValid_q) begin
        case (state_q)
          IDLE: begin
            if (scanByte_q == 8'hF0)      state_q  <= BREAK;
            else if (scanByte_q == 8'hE0) state_q  <= EXT;
            else if (scanByte_q == 8'h12) shiftL_q <= 1'b1;
            else if (scanByte_q == 8'h59) shiftR_q <= 1'b1;
            else if (scanByte_q == 8'h58) caps_q   <= ~caps_q;
            else if (lookupHit) begin
              key_q    <= lookupChar;
              pValid_q <= 1'b1;
            end
          end
          BREAK: begin
            if (scanByte_q == 8'h12)      shiftL_q <= 1'b0;
            else if (scanByte_q == 8'h59) shiftR_q <= 1'b0;
            state_q <= IDLE;
          end
          EXT: begin
            if (scanByte_q == 8'hF0) begin
              state_q <= EXT_BREAK;
            end else begin
              if (scanByte_q == 8'h5A) begin
                key_q    <= 8'h0A;
                pValid_q <= 1'b1;
              end
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_in     = key_q;
  assign p_valid    = pValid_q;
  assign shift_held = shiftL_q | shiftR_q;
  assign caps_lock  = caps_q;
  assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Self-checking bench for ps2_ascii_decoder: directed test-plan frames followed by random frames,
// all compared against a table-driven keyboard model.
module tb_ps2_ascii_decoder;

  localparam int TIMEOUT  = 300;
  localparam int SYNC     = 2;
  // Cycles from driving the 11th falling edge to seeing the strobe at a negedge sample
  localparam int EMIT_LAT = SYNC + 2;
  localparam int ERR_LAT  = SYNC + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_in;
  logic       p_valid, shift_held, caps_lock, frame_err;

  int checks = 0;
  int failures = 0;

  ps2_ascii_decoder #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_in(key_in), .p_valid(p_valid), .shift_held(shift_held),
    .caps_lock(caps_lock), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digitCodes [10]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] digitPlain [10]  = '{"1", "2", "3", "4", "5", "6", "7", "8", "9", "0"};
  logic [7:0] digitShift [10]  = '{"!", "@", "#", "$", "%", "^", "&", "*", "(", ")"};
  logic [7:0] pool [20]        = '{8'h1C, 8'h2D, 8'h1A, 8'h15, 8'h16, 8'h45, 8'h36, 8'h12, 8'h59, 8'h58,
                                   8'hF0, 8'hE0, 8'h5A, 8'h29, 8'h66, 8'h75, 8'h4D, 8'h3E, 8'h44, 8'h21};

  // Keyboard model state: pending prefix ("", "break", "ext", "extbreak"), modifier keys, last char
  string      mPrefix;
  bit         mShiftL, mShiftR, mCaps;
  logic [7:0] mKey;
  bit         expEmit;
  int         expTotal = 0;

  int obsEmitIdx, obsErrIdx, obsPulses, obsErrs;
  int totalPulses = 0;

  // Counts every strobe over the whole run, catching pulses outside the sampling windows
  always @(negedge clk) if (p_valid === 1'b1) totalPulses++;

  task automatic modelReset();
    mPrefix = "";
    mShiftL = 0; mShiftR = 0; mCaps = 0;
    mKey = 8'h00;
  endtask

  task automatic modelByte(input logic [7:0] b);
    expEmit = 0;
    if (mPrefix == "break") begin
      if (b == 8'h12) mShiftL = 0;
      if (b == 8'h59) mShiftR = 0;
      mPrefix = "";
    end else if (mPrefix == "ext") begin
      if (b == 8'hF0) mPrefix = "extbreak";
      else begin
        if (b == 8'h5A) begin expEmit = 1; mKey = 8'h0A; end
        mPrefix = "";
      end
    end else if (mPrefix == "extbreak") begin
      mPrefix = "";
    end else if (b == 8'hF0) mPrefix = "break";
    else if (b == 8'hE0) mPrefix = "ext";
    else if (b == 8'h12) mShiftL = 1;
    else if (b == 8'h59) mShiftR = 1;
    else if (b == 8'h58) mCaps = !mCaps;
    else begin
      for (int i = 0; i < 26; i++)
        if (b == letterCodes[i]) begin
          expEmit = 1;
          mKey = ((mShiftL || mShiftR) != mCaps) ? 8'(65 + i) : 8'(97 + i);
        end
      for (int i = 0; i < 10; i++)
        if (b == digitCodes[i]) begin
          expEmit = 1;
          mKey = (mShiftL || mShiftR) ? digitShift[i] : digitPlain[i];
        end
      if (b == 8'h29) begin expEmit = 1; mKey = 8'h20; end
      if (b == 8'h5A) begin expEmit = 1; mKey = 8'h0A; end
      if (b == 8'h66) begin expEmit = 1; mKey = 8'h08; end
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives nEdges bits of a frame; on the 11th edge samples the strobes for ten negedges
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input int nEdges);
    logic [10:0] f;
    f = {~badStop, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nEdges; i++) begin
      @(posedge clk); #1 ps2_data = f[i];
      repeat (8) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (i == 10) begin
        obsEmitIdx = -1; obsErrIdx = -1; obsPulses = 0; obsErrs = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (p_valid === 1'b1) begin
            obsPulses++;
            if (obsEmitIdx < 0) obsEmitIdx = k;
          end
          if (frame_err === 1'b1) begin
            obsErrs++;
            if (obsErrIdx < 0) obsErrIdx = k;
          end
        end
      end else begin
        repeat (8) @(posedge clk);
      end
      @(posedge clk); #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input bit bad);
    check({tag, ".emit_at"}, obsEmitIdx, expEmit ? EMIT_LAT : -1);
    check({tag, ".pulses"}, obsPulses, expEmit ? 1 : 0);
    check({tag, ".err_at"}, obsErrIdx, bad ? ERR_LAT : -1);
    check({tag, ".errs"}, obsErrs, bad ? 1 : 0);
    check({tag, ".key"}, int'(key_in), int'(mKey));
    check({tag, ".shift"}, int'(shift_held), int'(mShiftL || mShiftR));
    check({tag, ".caps"}, int'(caps_lock), int'(mCaps));
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badPar = 0, input bit badStop = 0);
    bit bad;
    bad = badPar || badStop;
    applyStimulus(b, badPar, badStop, 11);
    if (bad) expEmit = 0;
    else modelByte(b);
    expTotal += expEmit;
    checkOutput($sformatf("frame_%02h%s", b, bad ? "_bad" : ""), bad);
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    check({tag, ".key"}, int'(key_in), 0);
    check({tag, ".p_valid"}, int'(p_valid), 0);
    check({tag, ".shift"}, int'(shift_held), 0);
    check({tag, ".caps"}, int'(caps_lock), 0);
    check({tag, ".frame_err"}, int'(frame_err), 0);
  endtask

  initial begin
    logic [7:0] b;
    bit bp, bs;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    modelReset();
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    checkResetState("reset");

    $display("[TB] make/break of a");
    sendFrame(8'h1C); sendFrame(8'hF0); sendFrame(8'h1C);

    $display("[TB] shift handling");
    sendFrame(8'h12); sendFrame(8'h1C); sendFrame(8'hF0); sendFrame(8'h1C);
    sendFrame(8'hF0); sendFrame(8'h12); sendFrame(8'h1C);

    $display("[TB] caps lock");
    sendFrame(8'h58); sendFrame(8'hF0); sendFrame(8'h58); sendFrame(8'h1C);
    sendFrame(8'h12); sendFrame(8'h1C); sendFrame(8'h16);
    sendFrame(8'hF0); sendFrame(8'h12);

    $display("[TB] bad frames");
    sendFrame(8'h1C, 1, 0); sendFrame(8'h1C, 0, 1); sendFrame(8'h29);

    $display("[TB] timeout");
    applyStimulus(8'hAA, 0, 0, 5);
    repeat (TIMEOUT + 10) @(posedge clk);
    sendFrame(8'h5A);
    sendFrame(8'hE0); sendFrame(8'h5A);
    sendFrame(8'hE0); sendFrame(8'h75); sendFrame(8'hE0); sendFrame(8'hF0); sendFrame(8'h75);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h2D, 0, 0, 6);
    @(posedge clk); #1 reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    checkResetState("midreset");
    sendFrame(8'h2D);

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      b  = ($urandom_range(0, 15) < 12) ? pool[$urandom_range(0, 19)] : 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 9) == 0);
      sendFrame(b, bp, bs);
    end

    repeat (5) @(posedge clk);
    check("total_pulses", totalPulses, expTotal);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
